// File: rtl/byte_wb_master_pkg.sv
// -----------------------------------------------------------------------------
// byte_wb_master_pkg
// Shared definitions for the byte-stream to Wishbone bridge:
//   - state_t         : FSM state encoding
//   - HDR_*           : bit positions inside the frame header byte
//   - STATUS_*        : response status codes
//   - word_byte()     : pick one byte lane out of a 32-bit word
// -----------------------------------------------------------------------------
package byte_wb_master_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_DATA    = 3'd1,
        WB_CYCLE    = 3'd2,
        SEND_STATUS = 3'd3,
        SEND_DATA   = 3'd4
    } state_t;

    // Header byte layout: bit7 = write enable, bits6:4 unused, bits3:0 = address.
    localparam int HDR_WE_BIT  = 7;
    localparam int HDR_ADR_MSB = 3;
    localparam int HDR_ADR_LSB = 0;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;

    // Byte lane idx of a little-endian word (lane 0 = bits 7:0).
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/byte_wb_master_wb_timeout.sv
// -----------------------------------------------------------------------------
// wb_timeout
// Wait counter for the Wishbone access phase. Cleared on entry to the access
// phase, counts every cycle while enabled, and flags expiry once the access
// has been waiting TIMEOUT_CYCLES+1 cycles (expired is high during that last
// cycle). Only instantiated when WB_TIMEOUT_EN is defined.
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  synchronous active-high reset
//   clr     in  1  restart the count (first cycle of a new access follows)
//   en      in  1  access phase active, count this cycle
//   expired out 1  the current cycle is the last allowed wait cycle
// -----------------------------------------------------------------------------
module wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Counter is at least 8 bits, wider only if the limit needs it.
    localparam int unsigned CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW < 8) ? 8 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          expired_r;

    // Next count: restart on clear, saturate once the limit is reached.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (en && !expired_r) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register plus registered expiry flag derived from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            expired_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            expired_r <= (cnt_nxt_s == LIMIT);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/byte_wb_master.sv
// -----------------------------------------------------------------------------
// byte_wb_master
// Bridges a byte command stream to a single-beat Wishbone initiator.
// Frame: header byte (bit7 = we, bits3:0 = adr), then for writes 4 data bytes
// little-endian. Each access returns a status byte (0x00 ok, 0xEE timeout),
// followed for successful reads by the 4 read bytes, LSB first.
// Optional feature macro: WB_TIMEOUT_EN -- abort an access that has not been
// acknowledged within TIMEOUT_CYCLES+1 cycles (sub-module wb_timeout).
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   rx_data/rx_valid/rx_ready inbound command bytes (valid/ready)
//   tx_data/tx_valid/tx_ready outbound response bytes (valid/ready)
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_dat_o  Wishbone request
//   wb_dat_i/wb_ack_i         Wishbone response
//   busy                      high whenever the FSM is not in IDLE
// All outputs come straight from flops; flops are loaded from next-state values.
// -----------------------------------------------------------------------------
module byte_wb_master
    import byte_wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy
);

    state_t      state_r,     state_nxt_s;
    logic [1:0]  cnt_r,       cnt_nxt_s;
    logic        we_r,        we_nxt_s;
    logic [3:0]  adr_r,       adr_nxt_s;
    logic [31:0] dat_r,       dat_nxt_s;
    logic [31:0] rd_r,        rd_nxt_s;
    logic [7:0]  status_r,    status_nxt_s;
    logic [7:0]  tx_data_r,   tx_data_nxt_s;
    logic        rx_ready_r;
    logic        tx_valid_r;
    logic        wb_cyc_r;
    logic        busy_r;
    logic        rx_fire_s;
    logic        tx_fire_s;
    logic        expired_s;

    assign rx_fire_s = rx_valid && rx_ready_r;
    assign tx_fire_s = tx_valid_r && tx_ready;

`ifdef WB_TIMEOUT_EN
    logic tmo_clr_s;
    logic tmo_en_s;

    assign tmo_clr_s = (state_nxt_s == WB_CYCLE) && (state_r != WB_CYCLE);
    assign tmo_en_s  = (state_r == WB_CYCLE);

    wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wb_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state and datapath next values; everything holds unless a branch updates it.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        we_nxt_s      = we_r;
        adr_nxt_s     = adr_r;
        dat_nxt_s     = dat_r;
        rd_nxt_s      = rd_r;
        status_nxt_s  = status_r;
        tx_data_nxt_s = tx_data_r;
        case (state_r)
            IDLE: begin
                if (rx_fire_s) begin
                    we_nxt_s  = rx_data[HDR_WE_BIT];
                    adr_nxt_s = rx_data[HDR_ADR_MSB:HDR_ADR_LSB];
                    cnt_nxt_s = 2'd0;
                    if (rx_data[HDR_WE_BIT]) begin
                        state_nxt_s = GET_DATA;
                    end else begin
                        state_nxt_s = WB_CYCLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_fire_s) begin
                    dat_nxt_s[{cnt_r, 3'b000} +: 8] = rx_data;
                    cnt_nxt_s = cnt_r + 2'd1;
                    // 2-bit count wraps 3->0 on the fourth byte.
                    if (cnt_r == 2'd3) begin
                        state_nxt_s = WB_CYCLE;
                    end else begin
                        state_nxt_s = GET_DATA;
                    end
                end else begin
                    state_nxt_s = GET_DATA;
                end
            end
            WB_CYCLE: begin
                if (wb_ack_i) begin
                    if (!we_r) begin
                        rd_nxt_s = wb_dat_i;
                    end else begin
                        rd_nxt_s = rd_r;
                    end
                    status_nxt_s  = STATUS_OK;
                    tx_data_nxt_s = STATUS_OK;
                    state_nxt_s   = SEND_STATUS;
                end else if (expired_s) begin
                    status_nxt_s  = STATUS_TIMEOUT;
                    tx_data_nxt_s = STATUS_TIMEOUT;
                    state_nxt_s   = SEND_STATUS;
                end else begin
                    state_nxt_s = WB_CYCLE;
                end
            end
            SEND_STATUS: begin
                if (tx_fire_s) begin
                    // Writes and aborted accesses carry no data payload.
                    if (we_r || (status_r == STATUS_TIMEOUT)) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s   = SEND_DATA;
                        cnt_nxt_s     = 2'd0;
                        tx_data_nxt_s = word_byte(rd_r, 2'd0);
                    end
                end else begin
                    state_nxt_s = SEND_STATUS;
                end
            end
            SEND_DATA: begin
                if (tx_fire_s) begin
                    cnt_nxt_s = cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s   = SEND_DATA;
                        tx_data_nxt_s = word_byte(rd_r, cnt_r + 2'd1);
                    end
                end else begin
                    state_nxt_s = SEND_DATA;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers and state-decoded output flops (decoded from next state
    // so they line up with the state they describe).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 2'd0;
            we_r       <= 1'b0;
            adr_r      <= 4'd0;
            dat_r      <= 32'd0;
            rd_r       <= 32'd0;
            status_r   <= 8'd0;
            tx_data_r  <= 8'd0;
            rx_ready_r <= 1'b1;
            tx_valid_r <= 1'b0;
            wb_cyc_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            we_r       <= we_nxt_s;
            adr_r      <= adr_nxt_s;
            dat_r      <= dat_nxt_s;
            rd_r       <= rd_nxt_s;
            status_r   <= status_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            rx_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == GET_DATA);
            tx_valid_r <= (state_nxt_s == SEND_STATUS) || (state_nxt_s == SEND_DATA);
            wb_cyc_r   <= (state_nxt_s == WB_CYCLE);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign rx_ready = rx_ready_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign wb_cyc_o = wb_cyc_r;
    assign wb_stb_o = wb_cyc_r;
    assign wb_we_o  = we_r;
    assign wb_adr_o = adr_r;
    assign wb_dat_o = dat_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_byte_wb_master.sv
// -----------------------------------------------------------------------------
// tb_byte_wb_master
// Scoreboard bench: stimulus pushes the expected Wishbone accesses and response
// bytes into queues; independent monitors pop and compare whenever the DUT
// completes a Wishbone access or transfers a response byte.
// -----------------------------------------------------------------------------
module tb_byte_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        int          len;
        logic        acked;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [7:0] tx_q[$];

    int ack_mode   = 0;   // 0: tied high, 1: after 10 cycles, 2: never
    int stall_mode = 0;   // 1: hold tx_ready low 3 cycles per byte

    byte_wb_master #(.TIMEOUT_CYCLES(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                          input int len, input logic acked);
        wb_exp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.len = len; e.acked = acked;
        wb_q.push_back(e);
    endtask

    task automatic exp_read_resp(input logic [31:0] d);
        tx_q.push_back(8'h00);
        tx_q.push_back(d[7:0]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[31:24]);
    endtask

    task automatic wb_done(input logic acked, input int l, input logic we,
                           input logic [3:0] adr, input logic [31:0] dat);
        wb_exp_t e;
        if (wb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_unexpected: got access at adr %0h, required none", adr);
        end else begin
            e = wb_q.pop_front();
            check("wb_we", {63'd0, we}, {63'd0, e.we});
            check("wb_adr", {60'd0, adr}, {60'd0, e.adr});
            if (e.we) check("wb_dat", {32'd0, dat}, {32'd0, e.dat});
            check("wb_len", 64'(l), 64'(e.len));
            check("wb_acked", {63'd0, acked}, {63'd0, e.acked});
        end
    endtask

    // Wishbone responder: ack policy selected by ack_mode.
    int ack_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: wb_ack_i = 1'b1;
            1: begin
                if (wb_cyc_o) ack_cnt++;
                else ack_cnt = 0;
                wb_ack_i = (ack_cnt == 11);
            end
            default: wb_ack_i = 1'b0;
        endcase
    end

    // Response sink: always ready, or 3 stall cycles per byte.
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (stall_mode == 0) begin
            tx_ready  = 1'b1;
            stall_cnt = 0;
        end else if (tx_valid) begin
            if (stall_cnt < 3) begin
                tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready  = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            tx_ready  = 1'b0;
            stall_cnt = 0;
        end
    end

    // Wishbone monitor: records each access and scores it when it ends.
    logic        in_cyc = 1'b0;
    int          cyc_len = 0;
    logic        cur_we;
    logic [3:0]  cur_adr;
    logic [31:0] cur_dat;
    always @(negedge clk) begin
        if (rst) begin
            in_cyc  = 1'b0;
            cyc_len = 0;
        end else if (wb_cyc_o) begin
            if (!in_cyc) begin
                in_cyc  = 1'b1;
                cyc_len = 0;
                cur_we  = wb_we_o;
                cur_adr = wb_adr_o;
                cur_dat = wb_dat_o;
            end else begin
                check("wb_hold", {27'd0, wb_we_o, wb_adr_o, wb_dat_o},
                      {27'd0, cur_we, cur_adr, cur_dat});
            end
            check("wb_stb", {63'd0, wb_stb_o}, 64'd1);
            check("wb_rx_blocked", {63'd0, rx_ready}, 64'd0);
            cyc_len++;
            if (wb_ack_i) begin
                wb_done(1'b1, cyc_len, cur_we, cur_adr, cur_dat);
                in_cyc = 1'b0;
            end
        end else if (in_cyc) begin
            wb_done(1'b0, cyc_len, cur_we, cur_adr, cur_dat);
            in_cyc = 1'b0;
        end
    end

    // Response monitor: byte order, stall stability, rx blocking, idle return.
    logic       stalled  = 1'b0;
    logic       chk_idle = 1'b0;
    logic [7:0] prev_tx;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            stalled  = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_rx_ready", {63'd0, rx_ready}, 64'd1);
                chk_idle = 1'b0;
            end
            if (stalled) begin
                check("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
                check("tx_hold_data", {56'd0, tx_data}, {56'd0, prev_tx});
            end
            if (tx_valid) check("tx_rx_blocked", {63'd0, rx_ready}, 64'd0);
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %0h, required none", tx_data);
                end else begin
                    exp_b = tx_q.pop_front();
                    check("tx_byte", {56'd0, tx_data}, {56'd0, exp_b});
                    if (tx_q.size() == 0) chk_idle = 1'b1;
                end
            end
            stalled = tx_valid && !tx_ready;
            prev_tx = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_timeout: byte %0h not accepted, required acceptance", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || tx_q.size() != 0 || wb_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: busy=%0b wb_q=%0d tx_q=%0d, required idle and empty",
                     busy, wb_q.size(), tx_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
        check({tag, "_busy"},     {63'd0, busy},     64'd0);
        check({tag, "_cyc_stb"},  {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
        check({tag, "_we"},       {63'd0, wb_we_o},  64'd0);
        check({tag, "_tx_valid"}, {63'd0, tx_valid}, 64'd0);
        check({tag, "_adr_dat"},  {28'd0, wb_adr_o, wb_dat_o}, 64'd0);
        check({tag, "_tx_data"},  {56'd0, tx_data},  64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wb_dat_i = 32'h0;
        repeat (3) @(posedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write, ack tied high (also high while idle, must be ignored).
        exp_wb(1'b1, 4'h0, 32'h0000_0005, 1, 1'b1);
        tx_q.push_back(8'h00);
        send_byte(8'h80); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done();

        // Read, ack tied high.
        wb_dat_i = 32'h1234_5678;
        exp_wb(1'b0, 4'h2, 32'h0, 1, 1'b1);
        exp_read_resp(32'h1234_5678);
        send_byte(8'h02);
        wait_done();

        // Header bits 6:4 are don't-care.
        wb_dat_i = 32'h0000_00FF;
        exp_wb(1'b0, 4'hA, 32'h0, 1, 1'b1);
        exp_read_resp(32'h0000_00FF);
        send_byte(8'h7A);
        wait_done();

        // Write to top address with all-distinct data bytes.
        exp_wb(1'b1, 4'hF, 32'hEFBE_ADDE, 1, 1'b1);
        tx_q.push_back(8'h00);
        send_byte(8'hFF); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_done();

        // Stalled response; next header offered early and must wait.
        stall_mode = 1;
        wb_dat_i = 32'hA1B2_C3D4;
        exp_wb(1'b0, 4'h3, 32'h0, 1, 1'b1);
        exp_read_resp(32'hA1B2_C3D4);
        exp_wb(1'b0, 4'h5, 32'h0, 1, 1'b1);
        exp_read_resp(32'hA1B2_C3D4);
        send_byte(8'h03);
        send_byte(8'h05);
        wait_done();
        stall_mode = 0;

        // Ack delayed: 11 cycles of cyc/stb.
        ack_mode = 1;
        wb_dat_i = 32'hCAFE_F00D;
        exp_wb(1'b0, 4'hF, 32'h0, 11, 1'b1);
        exp_read_resp(32'hCAFE_F00D);
        send_byte(8'h0F);
        wait_done();
        ack_mode = 0;

        // Reset in the middle of a write frame: no access, no response.
        send_byte(8'h85); send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_wb(1'b1, 4'h1, 32'h0000_00AA, 1, 1'b1);
        tx_q.push_back(8'h00);
        send_byte(8'h81); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_done();

`ifdef WB_TIMEOUT_EN
        // No ack: abort after 256 cycles, status only, then a normal frame.
        ack_mode = 2;
        exp_wb(1'b0, 4'h4, 32'h0, 256, 1'b0);
        tx_q.push_back(8'hEE);
        send_byte(8'h04);
        wait_done();
        ack_mode = 0;
        exp_wb(1'b1, 4'h6, 32'h0403_0201, 1, 1'b1);
        tx_q.push_back(8'h00);
        send_byte(8'h86); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_done();
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("end_wb_q_empty", 64'(wb_q.size()), 64'd0);
        check("end_tx_q_empty", 64'(tx_q.size()), 64'd0);
        check("end_busy", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/byte_wb_master.md
BYTE_WB_MASTER -- requirements
Module: byte_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent waiting for ack (used only with WB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports rx_data  in  8 / rx_valid  in  1 / rx_ready  out  1: inbound command byte stream.
REQ-005 SHALL have ports tx_data  out  8 / tx_valid  out  1 / tx_ready  in  1: outbound response byte stream.
REQ-006 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  out  1 / wb_adr_o  out  4 / wb_dat_o  out  32: Wishbone initiator request.
REQ-007 SHALL have ports wb_dat_i  in  32 / wb_ack_i  in  1: Wishbone responder return.
REQ-008 SHALL have port busy  out  1: high whenever state != IDLE.

Function
REQ-009 SHALL transfer a byte only on a rising edge where valid && ready; tx_data SHALL remain stable while tx_valid && !tx_ready.
REQ-010 SHALL decode the frame header byte as: bit7 = we, bits6:4 ignored, bits3:0 = address.
REQ-011 SHALL implement states IDLE, GET_DATA, WB_CYCLE, SEND_STATUS and SEND_DATA.
REQ-012 SHALL drive rx_ready=1 only in IDLE and GET_DATA; in every other state it SHALL be 0.
REQ-013 IDLE: on header accept, latch we/adr; we=1 -> GET_DATA with byte count 0; we=0 -> WB_CYCLE.
REQ-014 GET_DATA: SHALL accept 4 bytes little-endian into wb_dat_o[7:0] first; after the 4th byte (2-bit count wraps 3->0) -> WB_CYCLE.
REQ-015 WB_CYCLE: wb_cyc_o=wb_stb_o=1 from the first cycle in the state, with wb_we_o/wb_adr_o/wb_dat_o held constant.
REQ-016 WB_CYCLE: on the edge where wb_ack_i=1, SHALL capture wb_dat_i (reads only), set status 0x00, and move to SEND_STATUS; wb_cyc_o/wb_stb_o SHALL be 0 in the following cycle.
REQ-017 A permanently-high ack SHALL yield exactly one cycle of wb_cyc_o.
REQ-018 SEND_STATUS: tx_valid=1 and tx_data=status; on accept -> IDLE for a write or a timed-out access, otherwise -> SEND_DATA.
REQ-019 SEND_DATA: SHALL send 4 captured bytes, LSB first, then -> IDLE; tx_valid SHALL be 0 outside SEND_STATUS/SEND_DATA.
REQ-020 wb_ack_i outside WB_CYCLE SHALL be ignored; rx_valid outside IDLE/GET_DATA SHALL be ignored and the byte not consumed.
REQ-021 A new header SHALL be accepted on the first cycle back in IDLE (zero dead cycles).

Reset
REQ-022 On rst: state=IDLE; wb_cyc_o, wb_stb_o, wb_we_o, tx_valid, busy = 0; wb_adr_o=0, wb_dat_o=0, tx_data=0; byte count=0; rx_ready=1 from the first cycle after reset.
REQ-023 rst SHALL abort any in-flight wishbone cycle or partial frame with no response emitted.

Configuration
REQ-024 With WB_TIMEOUT_EN defined: an 8-bit-or-wider wait counter clears on entry to WB_CYCLE; if ack is absent for TIMEOUT_CYCLES+1 cycles, SHALL drop cyc/stb, set status 0xEE, go to SEND_STATUS, and skip SEND_DATA.
REQ-025 Without WB_TIMEOUT_EN: no counter is present and WB_CYCLE waits for ack indefinitely.

Structure
REQ-026 A shared package SHALL hold the state enum, header bit positions, STATUS_OK=8'h00 and STATUS_TIMEOUT=8'hEE.
REQ-027 The FSM and datapath SHALL reside in one module; the optional timeout counter SHALL be sub-module wb_timeout.

Verification
REQ-028 Scenario: rx 80 05 00 00 00, ack tied high -> exactly one wb cycle with we=1, adr=0, dat=0x00000005; tx 00.
REQ-029 Scenario: rx 02, wb_dat_i=0x12345678, ack tied high -> one read cycle at adr=2; tx 00 78 56 34 12.
REQ-030 Scenario: read with tx_ready held low for 3 cycles on each byte -> tx_data unchanged during stall; byte order intact; no rx accepted until done.
REQ-031 Scenario: ack delayed 10 cycles -> cyc/stb high for exactly 11 cycles; response emitted afterwards.
REQ-032 Scenario (WB_TIMEOUT_EN, TIMEOUT_CYCLES=255): ack never asserted -> cyc drops after 256 cycles; tx EE only; following frame processed normally.
REQ-033 Scenario: rst pulsed after 2 of 4 data bytes -> no wb cycle; the next frame 81 AA 00 00 00 writes 0x000000AA to adr 1.
